// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like port arbiter: owner tags, size encodings,
// grant-select encoding and the select-to-owner mapping.
package sram_like_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_INST = 2'd1,
    SEL_DATA = 2'd2
  } sel_e;

  function automatic logic owner_of(input sel_e sel);
    return (sel == SEL_DATA) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per accepted-but-unanswered request.
// Head is read straight from storage so the response steering is combinational.
module arb_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     push_owner,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic          mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rptr_r];
  assign count     = count_r;

  // Owner storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= OWNER_INST;
      end
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= push_owner;
        wptr_r        <= wptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between instruction fetch and load/store with data
// priority, an anti-starvation override for fetch, and in-order response steering.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_MAX  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           inst_req,
  input  logic                           inst_wr,
  input  logic [1:0]                     inst_size,
  input  logic [ADDR_W-1:0]              inst_addr,
  input  logic [DATA_W-1:0]              inst_wdata,
  output logic                           inst_addr_ok,
  output logic                           inst_data_ok,
  output logic [DATA_W-1:0]              inst_rdata,
  input  logic                           data_req,
  input  logic                           data_wr,
  input  logic [1:0]                     data_size,
  input  logic [ADDR_W-1:0]              data_addr,
  input  logic [DATA_W-1:0]              data_wdata,
  output logic                           data_addr_ok,
  output logic                           data_data_ok,
  output logic [DATA_W-1:0]              data_rdata,
  output logic                           sram_req,
  output logic                           sram_wr,
  output logic [1:0]                     sram_size,
  output logic [ADDR_W-1:0]              sram_addr,
  output logic [DATA_W-1:0]              sram_wdata,
  input  logic                           sram_addr_ok,
  input  logic                           sram_data_ok,
  input  logic [DATA_W-1:0]              sram_rdata,
  output logic [$clog2(OUTSTANDING):0]   outstanding,
  output logic                           proto_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  sel_e          sel_s;
  logic          force_inst_s;
  logic          accept_s;
  logic          pop_s;
  logic          head_s;
  logic          full_s;
  logic          empty_s;
  logic [SW-1:0] starve_cnt_r;
  logic          proto_err_r;

  assign force_inst_s = inst_req & (starve_cnt_r == STARVE_LIM);

  // Grant select: gated by reset and by the registered full flag only.
  always_comb begin
    sel_s = SEL_NONE;
    if (!resetn || full_s) begin
      sel_s = SEL_NONE;
    end else if (data_req && !force_inst_s) begin
      sel_s = SEL_DATA;
    end else if (inst_req) begin
      sel_s = SEL_INST;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Request field mux; inst fields are presented whenever data is not selected.
  always_comb begin
    sram_wr    = inst_wr;
    sram_size  = inst_size;
    sram_addr  = inst_addr;
    sram_wdata = inst_wdata;
    if (sel_s == SEL_DATA) begin
      sram_wr    = data_wr;
      sram_size  = data_size;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else begin
      sram_wr    = inst_wr;
      sram_size  = inst_size;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end
  end

  assign sram_req     = (sel_s != SEL_NONE);
  assign accept_s     = sram_req & sram_addr_ok;
  assign inst_addr_ok = accept_s & (sel_s == SEL_INST);
  assign data_addr_ok = accept_s & (sel_s == SEL_DATA);

  assign pop_s        = sram_data_ok & ~empty_s & resetn;
  assign inst_data_ok = pop_s & (head_s == OWNER_INST);
  assign data_data_ok = pop_s & (head_s == OWNER_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;
  assign proto_err    = proto_err_r;

  arb_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept_s),
    .push_owner (owner_of(sel_s)),
    .pop        (pop_s),
    .head       (head_s),
    .count      (outstanding),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Consecutive data grants taken while fetch is waiting, saturating at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt_r <= '0;
    end else if (data_addr_ok && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Sticky flag for a response arriving with nothing in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err_r <= 1'b0;
    end else if (sram_data_ok && empty_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the arbitration and ordering rules.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int OUTSTANDING = 4;
  localparam int STARVE_MAX  = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int CW          = $clog2(OUTSTANDING) + 1;

  logic              clk;
  logic              resetn;
  logic              inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata, inst_rdata;
  logic              data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [1:0]        sram_size;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic [CW-1:0]     outstanding;
  logic              proto_err;

  sram_like_arbiter #(
    .OUTSTANDING (OUTSTANDING),
    .STARVE_MAX  (STARVE_MAX),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_req     (sram_req),
    .sram_wr      (sram_wr),
    .sram_size    (sram_size),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata),
    .outstanding  (outstanding),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, advanced once per cycle by the monitor.
  bit owner_q[$];
  int starve_m;
  bit perr_m;
  bit g_inst_m, g_data_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: predicts the cycle's grant and response from the model, compares, then advances the model.
  always @(negedge clk) begin
    bit full_m, pick_i, pick_d, exp_owner;
    if (!resetn) begin
      chk("rst_sram_req", sram_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_data_oks", {inst_data_ok, data_data_ok}, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_proto_err", proto_err, 0);
      owner_q.delete();
      starve_m = 0;
      perr_m   = 1'b0;
      g_inst_m = 1'b0;
      g_data_m = 1'b0;
    end else begin
      full_m = (owner_q.size() >= OUTSTANDING);
      pick_i = !full_m && inst_req && (starve_m >= STARVE_MAX || !data_req);
      pick_d = !full_m && data_req && !pick_i;
      chk("sram_req", sram_req, pick_i | pick_d);
      chk("inst_addr_ok", inst_addr_ok, pick_i & sram_addr_ok);
      chk("data_addr_ok", data_addr_ok, pick_d & sram_addr_ok);
      chk("sram_addr", sram_addr, pick_d ? data_addr : inst_addr);
      chk("sram_wdata", sram_wdata, pick_d ? data_wdata : inst_wdata);
      chk("sram_wr_size", {sram_wr, sram_size}, pick_d ? {data_wr, data_size} : {inst_wr, inst_size});
      chk("outstanding", outstanding, owner_q.size());
      chk("proto_err", proto_err, perr_m);
      if (sram_data_ok && owner_q.size() == 0) begin
        chk("spurious_no_fwd", {inst_data_ok, data_data_ok}, 0);
        perr_m = 1'b1;
      end else if (sram_data_ok) begin
        exp_owner = owner_q.pop_front();
        chk("resp_inst_ok", inst_data_ok, exp_owner == OWNER_INST);
        chk("resp_data_ok", data_data_ok, exp_owner == OWNER_DATA);
        chk("inst_rdata", inst_rdata, sram_rdata);
        chk("data_rdata", data_rdata, sram_rdata);
      end else begin
        chk("no_resp", {inst_data_ok, data_data_ok}, 0);
      end
      g_inst_m = pick_i & sram_addr_ok;
      g_data_m = pick_d & sram_addr_ok;
      if (g_inst_m) owner_q.push_back(OWNER_INST);
      if (g_data_m) owner_q.push_back(OWNER_DATA);
      if (!inst_req || g_inst_m) starve_m = 0;
      else if (g_data_m && starve_m < STARVE_MAX) starve_m++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    inst_req     = 1'b0;
    data_req     = 1'b0;
    sram_addr_ok = 1'b0;
    for (int k = 0; k < 20 && owner_q.size() > 0; k++) begin
      sram_data_ok = 1'b1;
      step();
    end
    sram_data_ok = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  int grants[6];
  int exp_g[6] = '{1, 1, 1, 1, 2, 1};

  initial begin
    resetn = 1'b0;
    {inst_req, inst_wr, data_req, data_wr, sram_addr_ok, sram_data_ok} = 6'b0;
    inst_size = SIZE_WORD;  data_size = SIZE_WORD;
    inst_addr = '0; inst_wdata = '0; data_addr = '0; data_wdata = '0; sram_rdata = '0;
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Single load with a 3-cycle response.
    data_req = 1'b1; data_addr = 32'h1000_0004; data_size = SIZE_WORD; sram_addr_ok = 1'b1;
    @(negedge clk) chk("t1_addr_ok", data_addr_ok, 1);
    step(); data_req = 1'b0; sram_addr_ok = 1'b0;
    step();
    step(); sram_data_ok = 1'b1; sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk) begin
      chk("t1_data_ok", data_data_ok, 1);
      chk("t1_rdata", data_rdata, 32'hDEAD_BEEF);
      chk("t1_inst_ok", inst_data_ok, 0);
    end
    step(); sram_data_ok = 1'b0;
    @(negedge clk) chk("t1_out_zero", outstanding, 0);
    step();

    // Simultaneous requests: data first, then inst, responses in order.
    inst_req = 1'b1; inst_addr = 32'h0000_0100; data_req = 1'b1; data_addr = 32'h2000_0000; sram_addr_ok = 1'b1;
    @(negedge clk) chk("t2_addr_data", sram_addr, 32'h2000_0000);
    step(); data_req = 1'b0;
    @(negedge clk) chk("t2_inst_grant", inst_addr_ok, 1);
    step(); inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h1111_2222;
    @(negedge clk) chk("t2_resp_d", data_data_ok, 1);
    step(); sram_rdata = 32'h3333_4444;
    @(negedge clk) chk("t2_resp_i", inst_data_ok, 1);
    step(); sram_data_ok = 1'b0;

    // Full stall: four accepted, fifth waits one cycle past the freeing response.
    inst_req = 1'b1; sram_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h0000_0200 + 32'(4 * i);
      @(negedge clk) chk($sformatf("t3_accept%0d", i), inst_addr_ok, 1);
      step();
    end
    inst_addr = 32'h0000_0210;
    @(negedge clk) begin
      chk("t3_full_req", sram_req, 0);
      chk("t3_full_cnt", outstanding, 4);
    end
    step(); sram_data_ok = 1'b1;
    @(negedge clk) chk("t3_no_same_cycle", inst_addr_ok, 0);
    step(); sram_data_ok = 1'b0;
    @(negedge clk) chk("t3_next_cycle", inst_addr_ok, 1);
    step();
    drain();

    // Starvation: four data grants, then inst is forced, then data resumes.
    inst_req = 1'b1; data_req = 1'b1; sram_addr_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sram_data_ok = (owner_q.size() > 0);
      @(negedge clk) grants[c] = data_addr_ok ? 1 : (inst_addr_ok ? 2 : 0);
      step();
    end
    for (int c = 0; c < 6; c++) chk($sformatf("t4_grant%0d", c), grants[c], exp_g[c]);
    drain();

    // Spurious response with nothing in flight.
    sram_data_ok = 1'b1;
    @(negedge clk) chk("t5_no_fwd", {inst_data_ok, data_data_ok}, 0);
    step(); sram_data_ok = 1'b0;
    repeat (10) step();
    @(negedge clk) chk("t5_sticky", proto_err, 1);
    step();
    pulse_reset();

    // Reset in the middle of three in-flight requests.
    inst_req = 1'b1; sram_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_addr = 32'h0000_0300 + 32'(4 * i);
      step();
    end
    inst_req = 1'b0; data_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    #2 resetn = 1'b0; sram_data_ok = 1'b0;
    #1 begin
      chk("t6_req_in_rst", sram_req, 0);
      chk("t6_addr_ok_in_rst", data_addr_ok, 0);
      chk("t6_out_in_rst", outstanding, 0);
    end
    #4 resetn = 1'b1; data_req = 1'b0;
    step();
    chk("t6_out_after", outstanding, 0);
    sram_data_ok = 1'b1;
    step(); sram_data_ok = 1'b0;
    @(negedge clk) chk("t6_stale_err", proto_err, 1);
    step();
    pulse_reset();

    // Random traffic; a request stays asserted with stable fields until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (!(inst_req && !g_inst_m)) begin
        inst_req   = ($urandom_range(0, 99) < 50);
        inst_wr    = ($urandom_range(0, 9) == 0);
        inst_size  = SIZE_WORD;
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (!(data_req && !g_data_m)) begin
        data_req   = ($urandom_range(0, 99) < 50);
        data_wr    = $urandom_range(0, 1) == 1;
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      sram_addr_ok = ($urandom_range(0, 99) < 70);
      sram_data_ok = (owner_q.size() > 0) && ($urandom_range(0, 99) < 45);
      sram_rdata   = $urandom;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
